nmea_tx: RTL and testbench

- Transmit-side counterpart of the GPS NMEA/UART receive path.
- On a start pulse, snapshots the pedometer results (step count, steps-per-minute) and serializes the proprietary sentence "$PSTEP,ccccc,sss*HH\r\n" as 8N1 UART at 9600 baud.
- Drives a board TX pin for logging or host readout.
- Sits beside the step counter in top and shares its 100 MHz clock.

---
 rtl/nmea_tx_pkg.sv | 40 ++++
 rtl/nmea_tx_if.sv | 12 +
 rtl/nmea_tx_uart.sv | 55 +++++
 rtl/nmea_tx.sv | 157 +++++++++++++++
 tb/tb_nmea_tx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nmea_tx_pkg.sv
// Shared constants, state encoding and ASCII helpers for the $PSTEP sentence transmitter.
package nmea_tx_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  // Bytes per sentence: "$PSTEP,ccccc,sss*HH\r\n"
  localparam int SENT_LEN = 21;

  // "PSTEP", first character in the top byte
  localparam logic [39:0] HEADER = 40'h5053544550;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Nibble to uppercase ASCII hex character
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] r;
    if (nib < 4'd10) begin
      r = 8'h30 + {4'h0, nib};
    end else begin
      r = 8'h37 + {4'h0, nib};
    end
    return r;
  endfunction

  // BCD digit to ASCII digit
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO | {4'h0, d};
  endfunction

endpackage

// File: rtl/nmea_tx_if.sv
// Request/status bundle of the sentence transmitter: start + snapshot data in, tx pin and status out.
interface nmea_tx_if;
  logic        start;
  logic [15:0] step_count;
  logic [9:0]  spm;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, step_count, spm, input tx, busy, done);
  modport slave  (input start, step_count, spm, output tx, busy, done);
endinterface

// File: rtl/nmea_tx_uart.sv
// 8N1 byte serializer. in_ready rises during the last cycle of the stop bit so a
// byte offered then starts immediately and bytes stay back-to-back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx
);
  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;
  logic [8:0]    shreg;
  logic          bit_end;

  assign bit_end  = (clk_cnt == LAST_CLK);
  assign in_ready = !active || (bit_end && (bit_cnt == 4'd9));

  // Bit timing and shift-out; tx always reflects the current bit slot
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      bit_cnt <= 4'd0;
      clk_cnt <= '0;
      shreg   <= 9'h1FF;
      tx      <= 1'b1;
    end else if (in_valid && in_ready) begin
      shreg   <= {1'b1, in_data};
      tx      <= 1'b0;
      active  <= 1'b1;
      bit_cnt <= 4'd0;
      clk_cnt <= '0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/nmea_tx.sv
// $PSTEP sentence transmitter: snapshots the pedometer values on start, converts
// them to BCD, and streams the 21-byte sentence with checksum through the UART.
module nmea_tx
  import nmea_tx_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input logic      clk,
  input logic      rst,
  nmea_tx_if.slave bus
);
  localparam int         CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [4:0] END_IDX      = 5'(SENT_LEN);

  state_t      state;
  logic [4:0]  idx;
  logic [3:0]  conv_cnt;
  logic [7:0]  csum;
  logic [35:0] cnt_sh;    // {5 BCD digits, 16-bit binary}
  logic [27:0] spm_sh;    // {3 BCD digits, 16-bit binary}
  logic [9:0]  spm_sat;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_fire;
  logic [7:0]  byte_data;

  // One double-dabble step: add 3 to every digit >= 5, then shift left
  function automatic logic [35:0] dd_step_cnt(input logic [35:0] v);
    logic [35:0] a;
    a = v;
    for (int i = 0; i < 5; i++) begin
      if (a[16+4*i +: 4] >= 4'd5) begin
        a[16+4*i +: 4] = a[16+4*i +: 4] + 4'd3;
      end else begin
        a[16+4*i +: 4] = a[16+4*i +: 4];
      end
    end
    return {a[34:0], 1'b0};
  endfunction

  function automatic logic [27:0] dd_step_spm(input logic [27:0] v);
    logic [27:0] a;
    a = v;
    for (int i = 0; i < 3; i++) begin
      if (a[16+4*i +: 4] >= 4'd5) begin
        a[16+4*i +: 4] = a[16+4*i +: 4] + 4'd3;
      end else begin
        a[16+4*i +: 4] = a[16+4*i +: 4];
      end
    end
    return {a[26:0], 1'b0};
  endfunction

  assign spm_sat    = (bus.spm > 10'd999) ? 10'd999 : bus.spm;
  assign byte_valid = (state == SEND) && (idx != END_IDX);
  assign byte_fire  = byte_valid && byte_ready;

  // Sentence byte selected by the current byte index
  always_comb begin
    byte_data = ASCII_LF;
    case (idx)
      5'd0:    byte_data = ASCII_DOLLAR;
      5'd1:    byte_data = HEADER[39:32];
      5'd2:    byte_data = HEADER[31:24];
      5'd3:    byte_data = HEADER[23:16];
      5'd4:    byte_data = HEADER[15:8];
      5'd5:    byte_data = HEADER[7:0];
      5'd6:    byte_data = ASCII_COMMA;
      5'd7:    byte_data = digit_ascii(cnt_sh[35:32]);
      5'd8:    byte_data = digit_ascii(cnt_sh[31:28]);
      5'd9:    byte_data = digit_ascii(cnt_sh[27:24]);
      5'd10:   byte_data = digit_ascii(cnt_sh[23:20]);
      5'd11:   byte_data = digit_ascii(cnt_sh[19:16]);
      5'd12:   byte_data = ASCII_COMMA;
      5'd13:   byte_data = digit_ascii(spm_sh[27:24]);
      5'd14:   byte_data = digit_ascii(spm_sh[23:20]);
      5'd15:   byte_data = digit_ascii(spm_sh[19:16]);
      5'd16:   byte_data = ASCII_STAR;
      5'd17:   byte_data = hex_ascii(csum[7:4]);
      5'd18:   byte_data = hex_ascii(csum[3:0]);
      5'd19:   byte_data = ASCII_CR;
      5'd20:   byte_data = ASCII_LF;
      default: byte_data = ASCII_LF;
    endcase
  end

  // Sentence FSM: snapshot, 16-cycle BCD conversion, byte sequencing, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 5'd0;
      conv_cnt <= 4'd0;
      csum     <= 8'h00;
      cnt_sh   <= 36'd0;
      spm_sh   <= 28'd0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            cnt_sh   <= {20'd0, bus.step_count};
            spm_sh   <= {12'd0, 6'd0, spm_sat};
            csum     <= 8'h00;
            conv_cnt <= 4'd0;
            idx      <= 5'd0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          cnt_sh   <= dd_step_cnt(cnt_sh);
          spm_sh   <= dd_step_spm(spm_sh);
          conv_cnt <= conv_cnt + 4'd1;
          if (conv_cnt == 4'd15) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (byte_fire) begin
            idx <= idx + 5'd1;
            if ((idx >= 5'd1) && (idx <= 5'd15)) begin
              csum <= csum ^ byte_data;
            end
          end else if ((idx == END_IDX) && byte_ready) begin
            // LF stop bit is in its last cycle
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .rst      (rst),
    .in_valid (byte_valid),
    .in_ready (byte_ready),
    .in_data  (byte_data),
    .tx       (bus.tx)
  );
endmodule

// File: tb/tb_nmea_tx.sv
// Scoreboard bench for nmea_tx: stimulus pushes expected sentence bytes, a UART
// decoder pops and compares each received byte; timing checks run alongside.
module tb_nmea_tx;
  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;   // 16
  localparam int FRAME  = 210 * CPB;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   byte_cnt = 0;
  logic [7:0] exp_q[$];

  nmea_tx_if bus();

  nmea_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    else return 8'(55 + n);
  endfunction

  task automatic push_str(input string str);
    for (int i = 0; i < str.len(); i++) exp_q.push_back(str[i]);
  endtask

  task automatic push_computed(input int c, input int s);
    string body;
    logic [7:0] x;
    int ss;
    ss = (s > 999) ? 999 : s;
    body = $sformatf("PSTEP,%05d,%03d", c, ss);
    x = 8'h00;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    exp_q.push_back(8'h24);
    push_str(body);
    exp_q.push_back(8'h2A);
    exp_q.push_back(hex_char(int'(x[7:4])));
    exp_q.push_back(hex_char(int'(x[3:0])));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Done pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  // UART decoder / scoreboard monitor: samples bit centres, pops and compares
  initial begin : decoder
    int off;
    int s;
    int prev_start;
    int k;
    bit act;
    logic [7:0] b;
    logic [7:0] e;
    act = 1'b0; off = 0; s = 0; prev_start = -1; b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        act = 1'b0;
        prev_start = -1;
      end else if (!act) begin
        if (bus.busy !== 1'b1) prev_start = -1;
        if (bus.tx === 1'b0) begin
          act = 1'b1;
          off = 0;
          s = cyc;
          if (prev_start >= 0) check("byte_spacing", s - prev_start, 10 * CPB);
          prev_start = s;
        end
      end else begin
        off++;
        if (off % CPB == CPB / 2) begin
          k = off / CPB;
          if (k == 0) begin
            check("start_bit", int'(bus.tx), 0);
          end else if (k <= 8) begin
            b[k-1] = bus.tx;
          end else begin
            check("stop_bit", int'(bus.tx), 1);
            byte_cnt++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_byte: got 0x%02h, expected no byte", b);
            end else begin
              e = exp_q.pop_front();
              check("sentence_byte", int'(b), int'(e));
            end
            act = 1'b0;
          end
        end
      end
    end
  end

  // tx edge-interval monitor: every interval within a frame is a whole number of bits
  initial begin : edge_mon
    int last;
    logic prev;
    last = -1;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || bus.busy !== 1'b1) begin
        last = -1;
      end else if (bus.tx !== prev) begin
        if (last >= 0) check("bit_width_multiple", (cyc - last) % CPB, 0);
        last = cyc;
      end
      prev = bus.tx;
    end
  end

  // Drives start at the current negedge; sc is the cycle in which start is high
  task automatic start_frame(input logic [15:0] c, input logic [9:0] s, output int sc);
    int n;
    bus.step_count = c;
    bus.spm = s;
    bus.start = 1'b1;
    sc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    n = 0;
    while (bus.tx === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_start_bit_latency", cyc - sc, 18);
  endtask

  task automatic finish_frame(input int sc, input bit pulse_in_done);
    int n;
    int busy_low;
    bit seen;
    n = 0; busy_low = 0; seen = 1'b0;
    while (n < FRAME + 100) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_low++;
    end
    check("done_seen", int'(seen), 1);
    check("done_latency", cyc - sc, 18 + FRAME);
    check("busy_low_in_frame", busy_low, 0);
    check("busy_on_done", int'(bus.busy), 0);
    if (pulse_in_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  // Global time bound
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int sc;
    int d0;
    int lows;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.step_count = 16'd0;
    bus.spm = 10'd0;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(bus.tx), 1);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Hand-computed sentences
    push_str("$PSTEP,00012,087*4E\r\n");
    start_frame(16'd12, 10'd87, sc);
    finish_frame(sc, 1'b0);
    repeat (3) @(negedge clk);

    push_str("$PSTEP,00000,000*42\r\n");
    start_frame(16'd0, 10'd0, sc);
    finish_frame(sc, 1'b0);
    repeat (3) @(negedge clk);

    // Maximum count and spm saturation
    push_computed(65535, 1023);
    start_frame(16'd65535, 10'd1023, sc);
    finish_frame(sc, 1'b0);
    repeat (3) @(negedge clk);

    // Start re-pulsed mid-frame with changed inputs
    d0 = done_cnt;
    push_computed(54321, 321);
    start_frame(16'd54321, 10'd321, sc);
    while (cyc < sc + 18 + 30 * CPB + 20) @(negedge clk);
    bus.step_count = 16'd5;
    bus.spm = 10'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < sc + 18 + 200 * CPB + 20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_frame(sc, 1'b0);
    check("one_done_per_frame", done_cnt - d0, 1);

    // Start one cycle after done is accepted; start during done is ignored
    push_computed(5, 5);
    start_frame(16'd5, 10'd5, sc);
    finish_frame(sc, 1'b1);
    repeat (4) @(negedge clk);
    check("start_in_done_ignored", int'(bus.busy), 0);
    check("tx_idle_after_done", int'(bus.tx), 1);

    // Reset during data bit 4 of byte 9
    push_computed(777, 42);
    start_frame(16'd777, 10'd42, sc);
    while (cyc < sc + 18 + 90 * CPB + 5 * CPB + CPB / 2) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("tx_after_rst", int'(bus.tx), 1);
    check("busy_after_rst", int'(bus.busy), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    while (cyc < sc + 18 + FRAME + 10) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    check("tx_idle_after_rst", lows, 0);
    check("no_done_after_rst", done_cnt - d0, 0);
    check("busy_idle_after_rst", int'(bus.busy), 0);

    push_computed(40321, 500);
    start_frame(16'd40321, 10'd500, sc);
    finish_frame(sc, 1'b0);

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("decoded_byte_total", byte_cnt, 6 * 21 + 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
